// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state encoding, ALU operation codes and opcode constants shared by the multicycle controller.
package multicycle_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
endpackage

// File: rtl/multicycle_controller_cond_check.sv
// cond_check: ARM condition-code evaluation against stored NZCV flags.
// COND_FULL_EN selects the full condition set; otherwise only EQ, NE and AL pass.
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;
`ifdef COND_FULL_EN
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = !z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = !c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = !n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = !v;
            4'h8: cond_ex = c && !z;
            4'h9: cond_ex = !c || z;
            4'ha: cond_ex = n == v;
            4'hb: cond_ex = n != v;
            4'hc: cond_ex = !z && (n == v);
            4'hd: cond_ex = z || (n != v);
            default: cond_ex = 1'b1;
        endcase
    end
`else
    logic unused_flags;
    assign unused_flags = n ^ c ^ v;
    assign cond_ex = (cond == 4'h0) ? z : (cond == 4'h1) ? !z : (cond == 4'he);
`endif
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multi-cycle ARM-subset datapath; holds NZCV flags.
// Define COND_FULL_EN to decode every ARM condition code instead of only EQ/NE/AL.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int ALU_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTR,
    input  logic [3:0]       ALUFlags,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [ALU_W-1:0] ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic             Undef,
    output logic [3:0]       State
);
    state_t     state;
    logic [3:0] flags;
    logic       cond_ex;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cmd, alu;
    logic       pcw, memw, irw, regw, und;
    logic       unused_instr;
    assign op           = INSTR[27:26];
    assign funct        = INSTR[25:20];
    assign rd           = INSTR[15:12];
    assign cmd          = funct[4:1];
    assign unused_instr = ^{INSTR[19:16], INSTR[11:0]};
    cond_check u_cond (.cond(INSTR[31:28]), .flags(flags), .cond_ex(cond_ex));
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= FETCH;
            flags <= '0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: state <= (!cond_ex || op == 2'b11) ? FETCH :
                                 (op == OP_MEM) ? MEMADR :
                                 (op == OP_BR)  ? BRANCH :
                                 funct[5] ? EXECI : EXECR;
                EXECR, EXECI: begin
                    state <= (cmd == ALU_CMP) ? FETCH : ALUWB;
                    if (funct[0]) flags <= ALUFlags;
                end
                MEMADR: state <= funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                default: state <= FETCH;
            endcase
        end
    end
    always_comb begin
        pcw       = 1'b0;
        memw      = 1'b0;
        irw       = 1'b0;
        regw      = 1'b0;
        und       = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        alu       = ALU_ADD;
        RegSrc    = 2'b00;
        case (state)
            FETCH:  begin irw = 1'b1; pcw = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; und = cond_ex && op == 2'b11; end
            EXECR:  alu = cmd;
            EXECI:  begin ALUSrcB = 2'b01; alu = cmd; end
            ALUWB:  begin regw = 1'b1; pcw = rd == 4'hf; end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; pcw = rd == 4'hf; end
            MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; RegSrc = 2'b10; end
            BRANCH: begin RegSrc = 2'b01; ALUSrcB = 2'b01; ResultSrc = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
    end
    // Enables are gated by RESET so nothing writes while reset is held, even combinationally.
    assign PCWrite    = pcw & RESET;
    assign MemWrite   = memw & RESET;
    assign IRWrite    = irw & RESET;
    assign RegWrite   = regw & RESET;
    assign Undef      = und & RESET;
    assign ALUControl = ALU_W'(alu);
    assign ImmSrc     = op;
    assign State      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven and randomized checks of the multicycle controller against a path model.
module tb_multicycle_controller;
    import multicycle_pkg::*;
    logic        CLK = 1'b0, RESET;
    logic [31:0] INSTR;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Undef;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, State;

    multicycle_controller #(.ALU_W(4)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Undef(Undef), .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] rs;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] aluc;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic       undef;
    } obs_t;
    typedef struct {
        obs_t e;
        obs_t m;
        logic latch;
    } cyc_t;
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        int          cycles;
        string       name;
    } vec_t;

    obs_t       obs;
    cyc_t       q[$];
    vec_t       tbl[13];
    logic [3:0] flags_m;
    int         checks = 0, fails = 0;

    assign obs = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef};

`ifdef COND_FULL_EN
    localparam int GT_CYC = 4;
`else
    localparam int GT_CYC = 2;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
`ifdef COND_FULL_EN
        case (cd)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'ha: return n == v;
            4'hb: return n != v;
            4'hc: return !z && n == v;
            4'hd: return z || n != v;
            default: return 1'b1;
        endcase
`else
        return (cd == 4'h0) ? z : (cd == 4'h1) ? !z : (cd == 4'he);
`endif
    endfunction

    // Expected outputs of one cycle; m marks the fields that state actually defines.
    function automatic void push(input state_t s, input logic [31:0] in, input logic u, input logic latch);
        cyc_t r;
        r.e = '0;
        r.m = '0;
        r.latch = latch;
        r.e.st = s;
        r.e.imm = in[27:26];
        r.m.st = '1; r.m.pcw = 1; r.m.memw = 1; r.m.irw = 1; r.m.regw = 1;
        r.m.imm = '1; r.m.rsrc = '1; r.m.undef = 1;
        case (s)
            FETCH: begin
                r.e.irw = 1; r.e.pcw = 1; r.m.adr = 1; r.e.rs = 2; r.m.rs = '1;
                r.e.asa = 1; r.m.asa = 1; r.e.asb = 2; r.m.asb = '1; r.e.aluc = ALU_ADD; r.m.aluc = '1;
            end
            DECODE: begin
                r.e.asa = 1; r.m.asa = 1; r.e.asb = 2; r.m.asb = '1; r.e.aluc = ALU_ADD; r.m.aluc = '1;
                r.e.undef = u;
            end
            EXECR, EXECI: begin
                r.m.asa = 1; r.e.asb = (s == EXECI) ? 2'b01 : 2'b00; r.m.asb = '1;
                r.e.aluc = in[24:21]; r.m.aluc = '1;
            end
            ALUWB, MEMWB: begin
                r.e.rs = (s == MEMWB) ? 2'b01 : 2'b00; r.m.rs = '1; r.e.regw = 1;
                r.e.pcw = in[15:12] == 4'hf;
            end
            MEMADR: begin
                r.m.asa = 1; r.e.asb = 1; r.m.asb = '1; r.e.aluc = ALU_ADD; r.m.aluc = '1;
            end
            MEMRD: begin
                r.e.adr = 1; r.m.adr = 1;
            end
            MEMWR: begin
                r.e.adr = 1; r.m.adr = 1; r.e.memw = 1; r.e.rsrc = 2'b10;
            end
            BRANCH: begin
                r.e.rsrc = 2'b01; r.e.asb = 1; r.m.asb = '1; r.e.aluc = ALU_ADD; r.m.aluc = '1;
                r.e.rs = 2; r.m.rs = '1; r.e.pcw = 1;
            end
            default: ;
        endcase
        q.push_back(r);
    endfunction

    // Instruction class -> path of states, following the decode rules.
    function automatic void plan(input logic [31:0] in);
        logic ok;
        logic [1:0] op;
        ok = cond_ok(in[31:28], flags_m);
        op = in[27:26];
        q.delete();
        push(FETCH, in, 0, 0);
        push(DECODE, in, ok && op == 2'b11, 0);
        if (ok && op != 2'b11) begin
            if (op == OP_MEM) begin
                push(MEMADR, in, 0, 0);
                if (in[20]) begin
                    push(MEMRD, in, 0, 0);
                    push(MEMWB, in, 0, 0);
                end else push(MEMWR, in, 0, 0);
            end else if (op == OP_BR) push(BRANCH, in, 0, 0);
            else begin
                push(in[25] ? EXECI : EXECR, in, 0, in[20]);
                if (in[24:21] != ALU_CMP) push(ALUWB, in, 0, 0);
            end
        end
    endfunction

    // Called just after a rising edge with the DUT in FETCH.
    task automatic run(input logic [31:0] in, input logic rnd, input logic [3:0] af, input int exp_cyc, input string name);
        int n = 0;
        plan(in);
        INSTR = in;
        do begin
            ALUFlags = rnd ? 4'($urandom) : af;
            @(negedge CLK);
            checks++;
            if (n >= q.size()) begin
                fails++;
                $display("FAIL %s cycle %0d: got state %0d expected instruction already finished", name, n, State);
            end else if (((obs ^ q[n].e) & q[n].m) != '0) begin
                fails++;
                $display("FAIL %s cycle %0d: got outputs %h expected %h (mask %h)", name, n, obs, q[n].e, q[n].m);
            end
            @(posedge CLK);
            if (n < q.size() && q[n].latch) flags_m = ALUFlags;
            #1;
            n++;
        end while (State != FETCH && n < 10);
        check({name, " cycles"}, n, (exp_cyc < 0) ? q.size() : exp_cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  cmds [6];
        logic [31:0] w;
        tbl[0]  = '{32'hE2821005, 4'b0000, 4, "ADD imm"};
        tbl[1]  = '{32'hE0500000, 4'b0100, 4, "SUBS Z"};
        tbl[2]  = '{32'h0A000002, 4'b0000, 3, "BEQ taken"};
        tbl[3]  = '{32'h1A000002, 4'b0000, 2, "BNE skipped"};
        tbl[4]  = '{32'hE5943008, 4'b0000, 5, "LDR"};
        tbl[5]  = '{32'hE5843008, 4'b0000, 4, "STR"};
        tbl[6]  = '{32'hE3510000, 4'b0000, 3, "CMP"};
        tbl[7]  = '{32'h1A000002, 4'b0000, 3, "BNE taken"};
        tbl[8]  = '{32'hC2811001, 4'b0000, GT_CYC, "GT"};
        tbl[9]  = '{32'hEC000000, 4'b0000, 2, "UNDEF"};
        tbl[10] = '{32'hE28FF004, 4'b0000, 4, "ADD PC"};
        tbl[11] = '{32'hE594F008, 4'b0000, 5, "LDR PC"};
        tbl[12] = '{32'hE1812003, 4'b1111, 4, "ORR reg"};
        cmds = '{ALU_AND, ALU_SUB, ALU_ADD, ALU_ORR, ALU_MOV, ALU_CMP};
        RESET = 1'b0;
        INSTR = 32'h0;
        ALUFlags = 4'h0;
        flags_m = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset state", State, FETCH);
        check("reset PCWrite", PCWrite, 0);
        check("reset IRWrite", IRWrite, 0);
        check("reset Undef", Undef, 0);
        RESET = 1'b1;
        for (int i = 0; i < 13; i++) run(tbl[i].instr, 0, tbl[i].af, tbl[i].cycles, tbl[i].name);

        // Abort a store in MEMWR with a short reset pulse after flags hold Z=1.
        run(32'hE0500000, 0, 4'b0100, 4, "SUBS Z again");
        INSTR = 32'hE5843008;
        repeat (3) @(posedge CLK);
        #1;
        check("pre-reset state", State, MEMWR);
        check("pre-reset MemWrite", MemWrite, 1);
        #1 RESET = 1'b0;
        #1;
        check("abort MemWrite", MemWrite, 0);
        check("abort state", State, FETCH);
        check("abort PCWrite", PCWrite, 0);
        check("abort RegWrite", RegWrite, 0);
        flags_m = 4'h0;
        INSTR = 32'h0A000002;
        @(posedge CLK);
        #3 RESET = 1'b1;
        check("release state", State, FETCH);
        @(posedge CLK);
        #1;
        check("after release state", State, DECODE);
        @(posedge CLK);
        #1;
        check("flags cleared BEQ skip", State, FETCH);

        repeat (200) begin
            int r;
            w = $urandom;
            w[27:26] = 2'($urandom_range(0, 3));
            if (w[27:26] == OP_DP) w[24:21] = cmds[$urandom_range(0, 5)];
            r = $urandom_range(0, 3);
            if (r == 0) w[31:28] = 4'he;
            else if (r == 1) w[31:28] = {3'b000, 1'($urandom)};
            run(w, 1, 4'h0, -1, "random");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
